// File: rtl/mips_perf_pkg.sv
// mips_perf_pkg: monitor state enum, MIPS S codes, opcodes, rd_sel indices and opcode class decode
package mips_perf_pkg;
  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_RUN     = 2'd1,
    MON_HALTED  = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_t;
  localparam logic [3:0] S_IF = 4'b0000;
  localparam logic [3:0] S_ID = 4'b0001;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [2:0] SEL_CYC   = 3'd0;
  localparam logic [2:0] SEL_INSTR = 3'd1;
  localparam logic [2:0] SEL_RTYPE = 3'd2;
  localparam logic [2:0] SEL_LW    = 3'd3;
  localparam logic [2:0] SEL_SW    = 3'd4;
  localparam logic [2:0] SEL_BEQ   = 3'd5;
  localparam logic [2:0] SEL_J     = 3'd6;
  localparam logic [2:0] SEL_OTHER = 3'd7;
  localparam int CLS_N = 6;
  function automatic logic [CLS_N-1:0] op_class(input logic [5:0] op);
    logic [4:0] k;
    k = {op == OP_J, op == OP_BEQ, op == OP_SW, op == OP_LW, op == OP_RTYPE};
    return {~|k, k};
  endfunction
endpackage

// File: rtl/mips_perf_counter.sv
// mips_perf_counter: W-bit saturating counter; ports clk, rst, clr_i (sync clear), inc_i, cnt_o
module mips_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_perf_monitor.sv
// mips_perf_monitor: cycle/instruction/class counters, halt detect and watchdog for the multicycle MIPS; in clk rst en clr S inst addr rd_sel, out rd_data halted timeout halt_pc mon_state; class counters built under MIPS_PERF_CLASS_EN
module mips_perf_monitor
  import mips_perf_pkg::*;
#(
  parameter int          MAX_CYCLES = 500,
  parameter logic [31:0] HALT_INST  = 32'h08000024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [3:0]       S,
  input  logic [31:0]      inst,
  input  logic [31:0]      addr,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted,
  output logic             timeout,
  output logic [31:0]      halt_pc,
  output logic [1:0]       mon_state
);
  mon_state_t state_q, state_d;
  logic [3:0] prev_s_q;
  logic [31:0] halt_pc_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d, cyc_cnt, instr_cnt;
  logic run, halt_det, wd_exp, if_entry;
  assign run      = state_q == MON_RUN && en;
  assign halt_det = run && S == S_ID && inst == HALT_INST;
  assign wd_exp   = run && cyc_cnt == CNT_W'(MAX_CYCLES - 1);
  assign if_entry = run && S == S_IF && prev_s_q != S_IF;
  mips_perf_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .rst(rst), .clr_i(clr), .inc_i(run), .cnt_o(cyc_cnt)
  );
  mips_perf_counter #(.W(CNT_W)) u_instr (
    .clk(clk), .rst(rst), .clr_i(clr), .inc_i(if_entry), .cnt_o(instr_cnt)
  );
`ifdef MIPS_PERF_CLASS_EN
  logic [CNT_W-1:0] cls_cnt [CLS_N];
  logic [CLS_N-1:0] cls_hit;
  assign cls_hit = (run && S == S_ID) ? op_class(inst[31:26]) : '0;
  for (genvar i = 0; i < CLS_N; i++) begin : g_cls
    mips_perf_counter #(.W(CNT_W)) u_cls (
      .clk(clk), .rst(rst), .clr_i(clr), .inc_i(cls_hit[i]), .cnt_o(cls_cnt[i])
    );
  end
  always_comb rd_data_d = rd_sel == SEL_CYC ? cyc_cnt : rd_sel == SEL_INSTR ? instr_cnt : cls_cnt[rd_sel - SEL_RTYPE];
`else
  always_comb rd_data_d = rd_sel == SEL_CYC ? cyc_cnt : rd_sel == SEL_INSTR ? instr_cnt : '0;
`endif
  // halt outranks watchdog expiry; both only fire in RUN
  always_comb state_d = state_q == MON_IDLE ? (en ? MON_RUN : MON_IDLE) : halt_det ? MON_HALTED : wd_exp ? MON_TIMEOUT : state_q;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= MON_IDLE;
      prev_s_q  <= 4'hF;
      halt_pc_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_s_q  <= run ? S : prev_s_q;
      halt_pc_q <= halt_det ? addr : halt_pc_q;
      rd_data_q <= rd_data_d;
    end
  end
  assign rd_data   = rd_data_q;
  assign halted    = state_q == MON_HALTED;
  assign timeout   = state_q == MON_TIMEOUT;
  assign halt_pc   = halt_pc_q;
  assign mon_state = state_q;
endmodule

// File: tb/tb_mips_perf_monitor.sv
// tb_mips_perf_monitor: directed self-checking bench for mips_perf_monitor
module tb_mips_perf_monitor;
  logic clk = 0, rst = 1, en = 0, clr = 0;
  logic [3:0] S = 4'hF;
  logic [31:0] inst = '0, addr = '0;
  logic [2:0] rd_sel = '0;
  logic [31:0] rd_data, halt_pc;
  logic halted, timeout;
  logic [1:0] mon_state;
  int errs = 0, checks = 0;
  localparam logic [31:0] HALT = 32'h08000024;
  localparam logic [31:0] RTYP = 32'h00221820;
`ifdef MIPS_PERF_CLASS_EN
  localparam bit CLS = 1;
`else
  localparam bit CLS = 0;
`endif
  mips_perf_monitor dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .inst(inst), .addr(addr),
    .rd_sel(rd_sel), .rd_data(rd_data), .halted(halted), .timeout(timeout),
    .halt_pc(halt_pc), .mon_state(mon_state)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
    rd_sel = sel;
    tick();
    check(tag, rd_data, exp);
  endtask
  task automatic run_instr(input logic [31:0] w);
    S = 4'd0;
    tick();
    S = 4'd1;
    inst = w;
    tick();
    S = 4'd2;
    tick();
  endtask
  task automatic pulse_clr();
    en = 0;
    clr = 1;
    tick();
    clr = 0;
  endtask
  initial begin
    tick(2);
    rst = 0;
    check("rst_state", 32'(mon_state), 0);
    check("rst_rd", rd_data, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_pc", halt_pc, 0);
    en = 1;
    S = 4'd0;
    tick();
    check("idle_to_run", 32'(mon_state), 1);
    inst = RTYP;
    for (int r = 0; r < 5; r++)
      for (int s = 0; s < 4; s++) begin
        S = 4'(s);
        tick();
      end
    en = 0;
    rd(3'd0, 20, "s1_cyc");
    rd_sel = 3'd1;
    #2;
    check("s1_rd_latency", rd_data, 20);
    tick();
    check("s1_instr", rd_data, 5);
    rd(3'd2, CLS ? 5 : 0, "s1_rtype");
    rd(3'd3, 0, "s1_lw");
    rd(3'd7, 0, "s1_other");
    check("s1_paused_state", 32'(mon_state), 1);
    pulse_clr();
    check("clr_state", 32'(mon_state), 0);
    en = 1;
    tick();
    run_instr(32'h8C220004);
    run_instr(32'hAC220004);
    run_instr(32'h10220002);
    run_instr(32'h08000010);
    run_instr(32'h20220005);
    S = 4'd2;
    tick(24);
    check("pre_halt", 32'(halted), 0);
    S = 4'd1;
    inst = HALT;
    addr = 32'h90;
    tick();
    check("halt_flag", 32'(halted), 1);
    check("halt_state", 32'(mon_state), 2);
    check("halt_pc", halt_pc, 32'h90);
    S = 4'd0;
    addr = 32'h0;
    tick(3);
    S = 4'd1;
    tick(2);
    rd(3'd0, 40, "s2_cyc_frozen");
    rd(3'd1, 5, "s2_instr");
    rd(3'd2, 0, "s2_rtype");
    rd(3'd3, CLS ? 1 : 0, "s2_lw");
    rd(3'd4, CLS ? 1 : 0, "s2_sw");
    rd(3'd5, CLS ? 1 : 0, "s2_beq");
    rd(3'd6, CLS ? 2 : 0, "s2_j");
    rd(3'd7, CLS ? 1 : 0, "s2_other");
    rst = 1;
    tick();
    rst = 0;
    check("rst_mid_halted", 32'(halted), 0);
    check("rst_mid_pc", halt_pc, 0);
    en = 1;
    S = 4'd2;
    inst = 32'h0;
    tick();
    tick(499);
    check("wd_before", 32'(timeout), 0);
    tick();
    check("wd_timeout", 32'(timeout), 1);
    check("wd_state", 32'(mon_state), 3);
    tick(3);
    rd(3'd0, 500, "wd_cyc");
    pulse_clr();
    en = 1;
    tick();
    tick(499);
    S = 4'd1;
    inst = HALT;
    addr = 32'h44;
    tick();
    check("both_state", 32'(mon_state), 2);
    check("both_timeout", 32'(timeout), 0);
    check("both_pc", halt_pc, 32'h44);
    rd(3'd0, 500, "both_cyc");
    pulse_clr();
    en = 1;
    S = 4'd0;
    inst = RTYP;
    tick();
    for (int s = 0; s < 4; s++) begin
      S = 4'(s);
      tick();
    end
    en = 0;
    S = 4'd0;
    tick(10);
    check("pause_state", 32'(mon_state), 1);
    en = 1;
    for (int s = 0; s < 4; s++) begin
      S = 4'(s);
      tick();
    end
    en = 0;
    rd(3'd0, 8, "pause_cyc");
    rd(3'd1, 2, "pause_instr");
    en = 1;
    S = 4'd1;
    inst = HALT;
    addr = 32'h55;
    clr = 1;
    tick();
    clr = 0;
    en = 0;
    check("clr_halt_state", 32'(mon_state), 0);
    check("clr_halt_flag", 32'(halted), 0);
    check("clr_halt_pc", halt_pc, 0);
    rd(3'd0, 0, "clr_cyc");
    rd(3'd1, 0, "clr_instr");
    rd(3'd6, 0, "clr_j");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mips_perf_monitor.md
# mips_perf_monitor

Synthesizable execution monitor for the multicycle MIPS core. It sits directly downstream of `MIPS` and consumes its `S`, `inst` and `addr` outputs. It counts cycles, retired instructions and per-class instructions, detects the halt loop and enforces a cycle watchdog. The bench and on-board debug logic read results through a registered select port instead of parsing the display trace.

## Interface

Parameters:

- `MAX_CYCLES`, 500: watchdog limit in RUN cycles.
- `HALT_INST`, 32'h08000024: instruction word that marks program end (jump-to-self).
- `CNT_W`, 32: width of every counter and of `rd_data`.

Ports:

- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: counting enable; low pauses all counters.
- `clr`, input, 1: synchronous clear; returns the block to IDLE and zeroes the counters.
- `S`, input, 4: current FSM state from `MIPS`.
- `inst`, input, 32: instruction register from `MIPS`.
- `addr`, input, 32: PC/memory address from `MIPS`; used for trace capture only.
- `rd_sel`, input, 3: counter select.
- `rd_data`, output, `CNT_W`: selected counter, registered.
- `halted`, output, 1: sticky; program reached `HALT_INST`.
- `timeout`, output, 1: sticky; watchdog expired.
- `halt_pc`, output, 32: `addr` captured on the halt-detect cycle.
- `mon_state`, output, 2: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.

## Operation

- FSM transitions:
  - IDLE→RUN when `en`=1.
  - RUN→HALTED on halt detect.
  - RUN→TIMEOUT when `cyc_cnt` increments to `MAX_CYCLES`.
  - HALTED and TIMEOUT are sticky until `rst` or `clr`.
- In RUN with `en`=0, the state holds and no counter changes.
- `cyc_cnt` increments on every RUN cycle with `en`=1, including the halt-detect cycle and the timeout cycle.
- Instruction count: `instr_cnt` increments on IF entry, i.e. `S`==4'b0000 while the previous sampled `S`!=4'b0000. The first RUN cycle counts as an entry if `S`==0 (the previous-`S` register resets to 4'hF).
- Halt detect: `S`==4'b0001 (DECODE, IR valid) and `inst`==`HALT_INST`.
- Class decode: performed at DECODE on `inst[31:26]`: 0x00 R-type, 0x23 lw, 0x2b sw, 0x04 beq, 0x02 j, anything else "other". The halt instruction is counted as j.
- Counters are unsigned and saturate at all-ones; they never wrap.
- `rd_sel` mapping:
  - 0: cycles
  - 1: instructions
  - 2: R-type
  - 3: lw
  - 4: sw
  - 5: beq
  - 6: j
  - 7: other
- Priority within a cycle: `rst` > `clr` > halt > timeout > increment.
  - Halt and watchdog expiry in the same cycle → HALTED, `timeout`=0.
  - `clr` together with any event → IDLE, event dropped.
- Reset mid-RUN: everything returns to reset values on the next edge; no partial state survives.

## Timing

- Reset values:
  - `rd_data`=0, `halted`=0, `timeout`=0, `halt_pc`=0, `mon_state`=IDLE.
  - All counters 0, previous-`S` register 4'hF.
- Inputs are sampled on the rising edge. Counter updates are visible one cycle after the qualifying sample.
- `rd_data` is registered: its value reflects the `rd_sel` and counter contents of the previous edge, giving 1-cycle latency.
- `halted`, `timeout` and `mon_state` update on the edge that samples the event; they are driven directly from state registers.
- `halt_pc` is loaded on the same edge that sets `halted`.
- Throughput: one event per cycle per counter; no back-pressure to `MIPS`.

## Configuration

- `MIPS_PERF_CLASS_EN` defined: the six class counters and their decode are built, and `rd_sel` 2–7 return them.
- Undefined: the class counters and decode are omitted, and `rd_sel` 2–7 read 0. Cycle/instruction counting, halt detection and the watchdog are unchanged.

## Structure

- Package `mips_perf_pkg` holds:
  - the `mon_state_t` enum;
  - the `S` codes `S_IF`=4'b0000 and `S_ID`=4'b0001;
  - the opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`);
  - the `rd_sel` index constants.
- Sub-module `mips_perf_counter` is a `CNT_W` saturating counter with `clr`/`inc` inputs. It is instantiated once for cycles, once for instructions, and six times under the macro.

## Test plan

- Reset, `en`=1, drive an `S` pattern 0,1,2,3 ×5 with `inst`=0x00221820 → `instr_cnt`=5, R-type=5, `cyc_cnt`=20, `rd_data` correct one cycle after `rd_sel` changes.
- Feed lw, sw, beq, j, 0x20 (addi) one each at DECODE → `rd_sel` 3–7 each read 1, R-type reads 0.
- At cycle 40, present `inst`=0x08000024 with `S`=1 and `addr`=0x90 → `halted`=1 on the next edge, `halt_pc`=0x90, counters frozen thereafter.
- Never halt, `MAX_CYCLES`=500 → `timeout`=1 after exactly 500 RUN cycles, `cyc_cnt`=500. Also halt on cycle 500 → HALTED, `timeout`=0.
- Toggle `en` low for 10 cycles mid-run, then assert `clr` with a halt in the same cycle → counts exclude the paused cycles; after `clr` the state is IDLE with all zeros and `halted`=0.
- Build without `MIPS_PERF_CLASS_EN` → `rd_sel`=2..7 read 0, and cycle/instruction results match the first scenario.
